// File: rtl/vx_tcu_fedp_seq_if.sv
// vx_tcu_fedp_seq_if: command, operand, FEDP and response bundle for one FEDP lane sequencer
interface vx_tcu_fedp_seq_if #(
  parameter int N     = 2,
  parameter int XLEN  = 32,
  parameter int STEPW = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_fmt_s;
  logic [STEPW-1:0]    cmd_steps;
  logic [31:0]         cmd_c;
  logic                op_valid;
  logic                op_ready;
  logic [N*XLEN-1:0]   op_a;
  logic [N*XLEN-1:0]   op_b;
  logic                fedp_enable;
  logic [2:0]          fedp_fmt_s;
  logic [N*XLEN-1:0]   fedp_a;
  logic [N*XLEN-1:0]   fedp_b;
  logic [31:0]         fedp_c;
  logic [31:0]         fedp_d;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic                rsp_err;
  modport master (
    output cmd_valid, cmd_fmt_s, cmd_steps, cmd_c, op_valid, op_a, op_b, fedp_d, rsp_ready,
    input  cmd_ready, op_ready, fedp_enable, fedp_fmt_s, fedp_a, fedp_b, fedp_c, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_fmt_s, cmd_steps, cmd_c, op_valid, op_a, op_b, fedp_d, rsp_ready,
    output cmd_ready, op_ready, fedp_enable, fedp_fmt_s, fedp_a, fedp_b, fedp_c, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/vx_tcu_fedp_seq.sv
// vx_tcu_fedp_seq: steps one FEDP lane through K operand pairs, chaining each result back as c
module vx_tcu_fedp_seq #(
  parameter int N       = 2,
  parameter int XLEN    = 32,
  parameter int LATENCY = 4,
  parameter int STEPW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  output logic             busy,
  vx_tcu_fedp_seq_if.slave io
);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [STEPW-1:0] rem;
  logic [31:0]      acc;
  logic [2:0]       fmt;
  logic             err;
  logic             up;
  logic             fmt_ok;
  logic             cmd_fire;
  logic             op_fire;
  logic             capture;
  assign fmt_ok   = (io.cmd_fmt_s == 3'd2) || (io.cmd_fmt_s == 3'd3);
  assign cmd_fire = io.cmd_valid && io.cmd_ready;
  assign op_fire  = io.op_valid && io.op_ready;
  assign capture  = (state == WAIT) && (cnt == '0) && !flush;
  // up keeps cmd_ready low until the first clock after reset releases
  assign io.cmd_ready   = (state == IDLE) && up && !flush;
  assign io.op_ready    = (state == ISSUE) && !flush;
  assign io.fedp_enable = !flush && (((state == ISSUE) && io.op_valid) || (state == WAIT));
  assign io.fedp_fmt_s  = fmt;
  assign io.fedp_a      = (state == ISSUE) ? io.op_a : '0;
  assign io.fedp_b      = (state == ISSUE) ? io.op_b : '0;
  assign io.fedp_c      = (state == ISSUE) ? acc : '0;
  assign io.rsp_valid   = (state == RESP) && !flush;
  assign io.rsp_data    = (state == RESP) ? acc : '0;
  assign io.rsp_err     = (state == RESP) && err;
  assign busy           = (state != IDLE);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (cmd_fire) state_n = (!fmt_ok || io.cmd_steps == '0) ? RESP : ISSUE;
    else if (op_fire) state_n = WAIT;
    else if (state == WAIT && cnt == '0) state_n = (rem == STEPW'(1)) ? RESP : ISSUE;
    else if (state == RESP && io.rsp_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      rem <= '0;
      acc <= '0;
      fmt <= '0;
      err <= 1'b0;
      up  <= 1'b0;
    end else begin
      up <= 1'b1;
      if (cmd_fire) begin
        fmt <= io.cmd_fmt_s;
        rem <= io.cmd_steps;
        acc <= fmt_ok ? io.cmd_c : 32'h7FC0_0000;
        err <= !fmt_ok;
      end
      if (op_fire) cnt <= CW'(LATENCY - 1);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (capture) begin
        acc <= io.fedp_d;
        rem <= rem - 1'b1;
      end
    end
endmodule

// File: tb/tb_vx_tcu_fedp_seq.sv
// tb_vx_tcu_fedp_seq: table-driven checks of the FEDP sequencer against a behavioural FEDP pipeline
module tb_vx_tcu_fedp_seq;
  localparam int N = 2, XLEN = 32, LAT = 4, STEPW = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int checks = 0;
  int failures = 0;
  vx_tcu_fedp_seq_if #(.N(N), .XLEN(XLEN), .STEPW(STEPW)) io();
  vx_tcu_fedp_seq #(.N(N), .XLEN(XLEN), .LATENCY(LAT), .STEPW(STEPW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .busy(busy), .io(io)
  );
  always #5 clk = ~clk;
  function automatic real pow2(input int e);
    real r = 1.0;
    for (int i = 0; i < (e < 0 ? -e : e); i++) r = (e < 0) ? r / 2.0 : r * 2.0;
    return r;
  endfunction
  function automatic real e2r(input logic [15:0] h, input bit bf);
    int  e = bf ? int'(h[14:7]) : int'(h[14:10]);
    real m = bf ? 1.0 + real'(h[6:0]) / 128.0 : 1.0 + real'(h[9:0]) / 1024.0;
    real r;
    if (e == 0) return 0.0;
    r = m * pow2(e - (bf ? 127 : 15));
    return h[15] ? -r : r;
  endfunction
  function automatic real f2r(input logic [31:0] f);
    real r;
    if (f[30:23] == 8'd0) return 0.0;
    r = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
    return f[31] ? -r : r;
  endfunction
  function automatic logic [31:0] r2f(input real r);
    logic s;
    int   e = 0;
    real  m;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    m = s ? -r : r;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction
  function automatic logic [31:0] dotp(input logic [N*XLEN-1:0] a, input logic [N*XLEN-1:0] b,
                                       input logic [31:0] c, input logic [2:0] fmt);
    real s = f2r(c);
    for (int i = 0; i < 2 * N; i++) s += e2r(a[16*i +: 16], fmt == 3'd3) * e2r(b[16*i +: 16], fmt == 3'd3);
    return r2f(s);
  endfunction
  // behavioural FEDP: LAT enabled stages, result visible at the last stage
  logic [31:0] pipe [LAT] = '{default: 32'd0};
  assign io.fedp_d = pipe[LAT-1];
  always @(posedge clk)
    if (io.fedp_enable) begin
      pipe[0] <= dotp(io.fedp_a, io.fedp_b, io.fedp_c, io.fedp_fmt_s);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  typedef struct {
    logic [2:0]  fmt;
    logic [7:0]  steps;
    logic [31:0] c, a, b, d;
    logic        err;
    int          lat, ops, op_stall, rsp_stall;
  } vec_t;
  vec_t vecs [8];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input int id);
    int cyc = 0, ops = 0, ens = 0, last = 0;
    @(posedge clk); #1;
    io.cmd_valid = 1'b1; io.cmd_fmt_s = v.fmt; io.cmd_steps = v.steps; io.cmd_c = v.c;
    io.op_a = {2*N{v.a[15:0]}}; io.op_b = {2*N{v.b[15:0]}};
    io.op_valid = (v.op_stall == 0);
    @(negedge clk);
    chk($sformatf("v%0d cmd_ready", id), 32'(io.cmd_ready), 32'd1);
    @(posedge clk); #1;
    io.cmd_valid = 1'b0;
    cyc = 1;
    forever begin
      if (v.op_stall > 0) io.op_valid = (cyc > v.op_stall);
      @(negedge clk);
      if (cyc <= v.op_stall) begin
        chk($sformatf("v%0d stall enable c%0d", id, cyc), 32'(io.fedp_enable), 32'd0);
        chk($sformatf("v%0d stall op_ready c%0d", id, cyc), 32'(io.op_ready), 32'd1);
      end
      if (io.op_ready && io.op_valid) begin
        if (ops > 0) chk($sformatf("v%0d op spacing", id), 32'(cyc - last), 32'(LAT + 1));
        ops++;
        last = cyc;
      end
      if (io.fedp_enable) ens++;
      if (io.rsp_valid || cyc >= 3000) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("v%0d latency", id), 32'(cyc), 32'(v.lat));
    chk($sformatf("v%0d op fires", id), 32'(ops), 32'(v.ops));
    chk($sformatf("v%0d enables", id), 32'(ens), 32'(v.ops * (LAT + 1)));
    chk($sformatf("v%0d rsp_data", id), io.rsp_data, v.d);
    chk($sformatf("v%0d rsp_err", id), 32'(io.rsp_err), 32'(v.err));
    for (int i = 0; i < v.rsp_stall; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d held valid %0d", id, i), 32'(io.rsp_valid), 32'd1);
      chk($sformatf("v%0d held data %0d", id, i), io.rsp_data, v.d);
    end
    io.rsp_ready = 1'b1;
    @(posedge clk); #1;
    io.rsp_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d idle after rsp", id), {30'd0, busy, io.rsp_valid}, 32'd0);
  endtask
  task automatic abort(input bit use_reset);
    int seen = 0;
    @(posedge clk); #1;
    io.cmd_valid = 1'b1; io.cmd_fmt_s = 3'd2; io.cmd_steps = 8'd1; io.cmd_c = 32'h3F80_0000;
    io.op_a = {2*N{16'h3C00}}; io.op_b = {2*N{16'h4000}}; io.op_valid = 1'b1;
    @(posedge clk); #1;
    io.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    if (use_reset) reset = 1'b0;
    else flush = 1'b1;
    @(negedge clk);
    chk($sformatf("abort%0d enable", use_reset), 32'(io.fedp_enable), 32'd0);
    chk($sformatf("abort%0d handshakes", use_reset), {29'd0, io.cmd_ready, io.op_ready, io.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk($sformatf("abort%0d busy", use_reset), 32'(busy), 32'd0);
    repeat (8) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (io.rsp_valid || io.fedp_enable) seen++;
    end
    chk($sformatf("abort%0d quiet", use_reset), 32'(seen), 32'd0);
  endtask
  initial begin
    io.cmd_valid = 1'b0; io.cmd_fmt_s = 3'd0; io.cmd_steps = '0; io.cmd_c = '0;
    io.op_valid = 1'b0; io.op_a = '0; io.op_b = '0; io.rsp_ready = 1'b0;
    //           fmt   steps  c             a             b             d             err lat  ops stall rstall
    vecs[0] = '{3'd2, 8'd1,   32'h3F800000, 32'h3C003C00, 32'h40004000, 32'h41100000, 1'b0, 6,    1,   0, 0};
    vecs[1] = '{3'd2, 8'd3,   32'h3F800000, 32'h3C003C00, 32'h40004000, 32'h41C80000, 1'b0, 16,   3,   0, 0};
    vecs[2] = '{3'd3, 8'd1,   32'h00000000, 32'h3F803F80, 32'h40004000, 32'h41000000, 1'b0, 6,    1,   0, 0};
    vecs[3] = '{3'd2, 8'd0,   32'h12345678, 32'h3C003C00, 32'h40004000, 32'h12345678, 1'b0, 1,    0,   0, 0};
    vecs[4] = '{3'd5, 8'd1,   32'h3F800000, 32'h3C003C00, 32'h40004000, 32'h7FC00000, 1'b1, 1,    0,   0, 0};
    vecs[5] = '{3'd2, 8'd2,   32'h00000000, 32'hC000C000, 32'h3C003C00, 32'hC1800000, 1'b0, 11,   2,   0, 0};
    vecs[6] = '{3'd2, 8'd255, 32'h00000000, 32'h3C003C00, 32'h3C003C00, 32'h447F0000, 1'b0, 1276, 255, 0, 0};
    vecs[7] = '{3'd2, 8'd3,   32'h3F800000, 32'h3C003C00, 32'h40004000, 32'h41C80000, 1'b0, 19,   3,   3, 4};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {26'd0, io.cmd_ready, io.op_ready, io.fedp_enable, io.rsp_valid, io.rsp_err, busy}, 32'd0);
    chk("reset rsp_data", io.rsp_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("cmd_ready after reset", 32'(io.cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) run(vecs[i], i);
    abort(1'b0);
    run(vecs[0], 10);
    abort(1'b1);
    run(vecs[0], 11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vx_tcu_fedp_seq.md
Name: vx_tcu_fedp_seq

Overview:
Sequencer for one TCU fused dot-product (FEDP) lane. It accepts a dot-product command (format, K-step count, initial accumulator) and pulls one operand pair per K-step from an operand stream. It drives the FEDP unit's enable and operands, and chains each FEDP result back as the next step's c input. The final accumulator is returned on a valid/ready response port. It sits between the TCU issue/operand-collect logic and the FEDP datapath.

Parameters:
N, 2, XLEN words per operand row/column; each word carries two 16-bit elements.
XLEN, 32, word width.
LATENCY, 4, fixed FEDP pipeline depth in enabled cycles; must be >= 2.
STEPW, 8, width of the K-step count.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_fmt_s  in  3  source format; 2=fp16, 3=bf16
cmd_steps  in  STEPW  number of K-steps
cmd_c  in  32  initial fp32 accumulator
op_valid  in  1  operand pair valid
op_ready  out  1  operand pair ready
op_a  in  N*XLEN  A row operand
op_b  in  N*XLEN  B column operand
fedp_enable  out  1  FEDP pipeline advance
fedp_fmt_s  out  3  format to FEDP
fedp_a  out  N*XLEN  A operand to FEDP
fedp_b  out  N*XLEN  B operand to FEDP
fedp_c  out  32  accumulator input to FEDP
fedp_d  in  32  FEDP result
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_data  out  32  final fp32 accumulator
rsp_err  out  1  unsupported format flag
flush  in  1  synchronous abort
busy  out  1  high when state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0, including cmd_ready.
  - Internal acc, fmt, remaining steps and counter cleared.
  - cmd_ready rises in the first cycle after reset deasserts.
- State IDLE: cmd_ready=1; op_ready=0; fedp_enable=0.
  - On cmd fire: latch fmt, acc=cmd_c, rem=cmd_steps.
  - fmt not 2/3: acc=32'h7FC00000, err=1, go RESP.
  - Else cmd_steps==0: go RESP with acc=cmd_c, err=0.
  - Else go ISSUE.
- State ISSUE: op_ready=1; fedp_a/b=op_a/b (combinational); fedp_c=acc; fedp_fmt_s=fmt.
  - fedp_enable=op_valid.
  - On op fire: cnt=LATENCY-1, go WAIT.
  - No op_valid: stay in ISSUE, FEDP frozen.
- State WAIT: op_ready=0; fedp_enable=1 every cycle.
  - fedp_a/b/c are don't-care; drive 0.
  - cnt decrements each cycle.
  - When cnt==0, fedp_d holds the issued step's result: acc<=fedp_d, rem<=rem-1.
  - If rem==1, go RESP; else go ISSUE.
  - WAIT lasts exactly LATENCY cycles.
- State RESP: rsp_valid=1; rsp_data=acc; rsp_err=err; cmd_ready=0; fedp_enable=0.
  - On rsp_ready: go IDLE.
  - rsp_data/rsp_err hold stable while rsp_valid && !rsp_ready.
- Throughput: one K-step per LATENCY+1 cycles when op_valid is continuously high. No overlap between consecutive commands.
- Latency: a steps=S command with ops always valid fires cmd at cycle 0; rsp_valid asserts at cycle S*(LATENCY+1)+1.
- fedp_fmt_s=fmt in every state. It changes only in IDLE.
- flush: in any state, next state=IDLE and in-flight results are discarded.
  - In the flush cycle fedp_enable=0, and no handshake fires (cmd_ready, op_ready, rsp_valid are forced to 0).
  - flush has priority over all transitions.
- rem decrements only on result capture, so a step count of 2^STEPW-1 is legal. No wrap occurs because the S==0 case is trapped in IDLE.
- FEDP garbage from bubbles is never captured; capture happens only at the cnt==0 cycle.

Test Plan:
1. fp16, N=2, steps=1, cmd_c=0x3F800000; op_a words=0x3C003C00 (1.0), op_b words=0x40004000 (2.0) -> rsp_data=0x41100000 (9.0), rsp_valid at cycle 6, rsp_err=0.
2. fp16, steps=3, same operands every step, cmd_c=0x3F800000 -> rsp_data=0x41C80000 (25.0); op_ready pulses exactly 3 times, 5 cycles apart.
3. bf16, steps=1, cmd_c=0; op words=0x3F803F80 and 0x40004000 -> rsp_data=0x41000000 (8.0).
4. steps=0 with cmd_c=0x12345678 -> rsp_valid one cycle after cmd fire, rsp_data=0x12345678; fmt_s=5 -> rsp_data=0x7FC00000, rsp_err=1. Neither case pulses fedp_enable.
5. op_valid withheld 3 cycles in ISSUE, then rsp_ready low 4 cycles in RESP -> fedp_enable=0 during the gaps, result still 25.0 (scenario 2 data), rsp_data stable while stalled.
6. flush in mid-WAIT, and reset=0 in mid-WAIT -> IDLE next cycle, no rsp_valid. A following steps=1 command returns 0x41100000 (scenario 1).
